// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: bundle of the two requester channels, the shared multiplier
// drive/return signals and the response channel of mult_arbiter.
//
// Handshake rules, for every valid/ready pair in this bundle:
// a transfer happens on a rising clk edge where valid and ready are both high.
// Once valid rises, the producer holds valid and its payload unchanged until
// that transfer. Ready may depend combinationally on valid. The producer never
// waits for ready before raising valid.
`timescale 1ns/1ps

interface mult_arbiter_if;
  // requester 0
  logic        req0_valid_i;
  logic        req0_ready_o;
  logic [2:0]  req0_op_i;
  logic [1:0]  req0_signed_i;
  logic        req0_subword_i;
  logic [4:0]  req0_imm_i;
  logic [31:0] req0_a_i;
  logic [31:0] req0_b_i;
  logic [31:0] req0_c_i;
  // requester 1
  logic        req1_valid_i;
  logic        req1_ready_o;
  logic [2:0]  req1_op_i;
  logic [1:0]  req1_signed_i;
  logic        req1_subword_i;
  logic [4:0]  req1_imm_i;
  logic [31:0] req1_a_i;
  logic [31:0] req1_b_i;
  logic [31:0] req1_c_i;
  // shared multiplier
  logic        mult_enable_o;
  logic [2:0]  mult_operator_o;
  logic [1:0]  mult_signed_o;
  logic        mult_subword_o;
  logic [4:0]  mult_imm_o;
  logic [31:0] mult_op_a_o;
  logic [31:0] mult_op_b_o;
  logic [31:0] mult_op_c_o;
  logic        mult_ready_i;
  logic [31:0] mult_result_i;
  logic        mult_ex_ready_o;
  // response
  logic        rsp_valid_o;
  logic        rsp_id_o;
  logic [31:0] rsp_result_o;
  logic        rsp_ready_i;

  // arbiter side
  modport slave (
    input  req0_valid_i, req0_op_i, req0_signed_i, req0_subword_i, req0_imm_i,
           req0_a_i, req0_b_i, req0_c_i,
    input  req1_valid_i, req1_op_i, req1_signed_i, req1_subword_i, req1_imm_i,
           req1_a_i, req1_b_i, req1_c_i,
    output req0_ready_o, req1_ready_o,
    output mult_enable_o, mult_operator_o, mult_signed_o, mult_subword_o,
           mult_imm_o, mult_op_a_o, mult_op_b_o, mult_op_c_o, mult_ex_ready_o,
    input  mult_ready_i, mult_result_i,
    output rsp_valid_o, rsp_id_o, rsp_result_o,
    input  rsp_ready_i
  );

  // requesters, multiplier and response consumer side
  modport master (
    output req0_valid_i, req0_op_i, req0_signed_i, req0_subword_i, req0_imm_i,
           req0_a_i, req0_b_i, req0_c_i,
    output req1_valid_i, req1_op_i, req1_signed_i, req1_subword_i, req1_imm_i,
           req1_a_i, req1_b_i, req1_c_i,
    input  req0_ready_o, req1_ready_o,
    input  mult_enable_o, mult_operator_o, mult_signed_o, mult_subword_o,
           mult_imm_o, mult_op_a_o, mult_op_b_o, mult_op_c_o, mult_ex_ready_o,
    output mult_ready_i, mult_result_i,
    input  rsp_valid_o, rsp_id_o, rsp_result_o,
    output rsp_ready_i
  );
endinterface

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one multiplier between two requesters.
// IDLE accepts one request, BUSY drives the multiplier until it reports a
// result, RESP presents the result until the consumer takes it.
// Optional feature macro: MULT_ARB_ROUND_ROBIN_EN. When defined, ties go to
// the requester that did not win the last handshake; when undefined,
// requester 0 always wins ties and no last-grant state exists.
// The multiplier must share rst_n with this block so both idle together.
`timescale 1ns/1ps

module mult_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  mult_arbiter_if.slave bus,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic        accept_en;   // low from reset until the first clock after release
  logic        grant0;
  logic        grant1;
  logic        hs0;
  logic        hs1;
  logic        hs;

  logic [2:0]  op_q;
  logic [1:0]  signed_q;
  logic        subword_q;
  logic [4:0]  imm_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] c_q;
  logic        owner_q;
  logic [31:0] result_q;
  logic        enable_q;
  logic        rsp_valid_q;

`ifdef MULT_ARB_ROUND_ROBIN_EN
  logic last_grant;

  // Round-robin grant: on a tie, the requester other than last_grant wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = bus.req0_valid_i;
      grant1 = bus.req1_valid_i;
    end
  end

  // Remember the winner of each completed request handshake; 1 after reset
  // so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (hs) begin
      last_grant <= hs1;
    end
  end
`else
  // Fixed priority: requester 0 wins every tie.
  assign grant0 = bus.req0_valid_i;
  assign grant1 = bus.req1_valid_i && !bus.req0_valid_i;
`endif

  // Ready is the grant itself, only while idle and out of reset, so at most
  // one requester sees ready and a lone requester is accepted immediately.
  assign bus.req0_ready_o = accept_en && (state == IDLE) && grant0;
  assign bus.req1_ready_o = accept_en && (state == IDLE) && grant1;

  assign hs0 = bus.req0_valid_i && bus.req0_ready_o;
  assign hs1 = bus.req1_valid_i && bus.req1_ready_o;
  assign hs  = hs0 || hs1;

  // Control FSM with registered payload, result and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      accept_en   <= 1'b0;
      op_q        <= 3'd0;
      signed_q    <= 2'd0;
      subword_q   <= 1'b0;
      imm_q       <= 5'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      c_q         <= 32'd0;
      owner_q     <= 1'b0;
      result_q    <= 32'd0;
      enable_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      accept_en <= 1'b1;
      case (state)
        IDLE: begin
          if (hs) begin
            op_q      <= hs1 ? bus.req1_op_i      : bus.req0_op_i;
            signed_q  <= hs1 ? bus.req1_signed_i  : bus.req0_signed_i;
            subword_q <= hs1 ? bus.req1_subword_i : bus.req0_subword_i;
            imm_q     <= hs1 ? bus.req1_imm_i     : bus.req0_imm_i;
            a_q       <= hs1 ? bus.req1_a_i       : bus.req0_a_i;
            b_q       <= hs1 ? bus.req1_b_i       : bus.req0_b_i;
            c_q       <= hs1 ? bus.req1_c_i       : bus.req0_c_i;
            owner_q   <= hs1;
            enable_q  <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Multi-step operations simply keep us here; there is no timeout.
          if (bus.mult_ready_i) begin
            result_q    <= bus.mult_result_i;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          enable_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // The multiplier only returns to idle when ex_ready accompanies its ready,
  // so this release must be combinational with the capture cycle.
  assign bus.mult_ex_ready_o = (state == BUSY) && bus.mult_ready_i;

  assign bus.mult_enable_o   = enable_q;
  assign bus.mult_operator_o = op_q;
  assign bus.mult_signed_o   = signed_q;
  assign bus.mult_subword_o  = subword_q;
  assign bus.mult_imm_o      = imm_q;
  assign bus.mult_op_a_o     = a_q;
  assign bus.mult_op_b_o     = b_q;
  assign bus.mult_op_c_o     = c_q;

  assign bus.rsp_valid_o     = rsp_valid_q;
  assign bus.rsp_id_o        = owner_q;
  assign bus.rsp_result_o    = result_q;

  assign dbg_state           = state;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed, table-driven bench for mult_arbiter with a
// behavioural model of the shared multiplier (single-step ops answer in the
// first enabled cycle, high multiply on the fourth).
`timescale 1ns/1ps

module tb_mult_arbiter;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  mult_arbiter_if bus();

  mult_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULT_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam logic [2:0] OP_MAC32 = 3'b000;
  localparam logic [2:0] OP_MSU32 = 3'b001;
  localparam logic [2:0] OP_MUL_I = 3'b010;
  localparam logic [2:0] OP_MUL_H = 3'b110;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  int          cyc       = 0;
  int          ex_pulses = 0;

  // ---------------- multiplier model ----------------
  int mcnt;

  function automatic logic [31:0] mult_model(input logic [2:0] op, input logic [1:0] sg,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
    logic [63:0] pa;
    logic [63:0] pb;
    logic [63:0] p;
    pa = sg[0] ? {{32{a[31]}}, a} : {32'd0, a};
    pb = sg[1] ? {{32{b[31]}}, b} : {32'd0, b};
    p  = pa * pb;
    case (op)
      OP_MAC32: return a * b + c;
      OP_MSU32: return c - a * b;
      OP_MUL_H: return p[63:32];
      default:  return a * b;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 0;
    else if (!bus.mult_enable_o || bus.mult_ex_ready_o) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  always_comb begin
    bus.mult_ready_i  = 1'b0;
    bus.mult_result_i = 32'd0;
    if (bus.mult_enable_o) begin
      bus.mult_ready_i  = (bus.mult_operator_o == OP_MUL_H) ? (mcnt == 3) : 1'b1;
      bus.mult_result_i = mult_model(bus.mult_operator_o, bus.mult_signed_o,
                                     bus.mult_op_a_o, bus.mult_op_b_o, bus.mult_op_c_o);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.mult_ex_ready_o) ex_pulses <= ex_pulses + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, " rsp_valid"},   32'(bus.rsp_valid_o),     32'd0);
    check({nm, " rsp_id"},      32'(bus.rsp_id_o),        32'd0);
    check({nm, " rsp_result"},  bus.rsp_result_o,         32'd0);
    check({nm, " mult_enable"}, 32'(bus.mult_enable_o),   32'd0);
    check({nm, " ex_ready"},    32'(bus.mult_ex_ready_o), 32'd0);
    check({nm, " ready0"},      32'(bus.req0_ready_o),    32'd0);
    check({nm, " ready1"},      32'(bus.req1_ready_o),    32'd0);
    check({nm, " op_a"},        bus.mult_op_a_o,          32'd0);
    check({nm, " state"},       32'(dbg_state),           32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input bit sel, input bit v, input logic [2:0] op,
                           input logic [1:0] sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c);
    if (!sel) begin
      bus.req0_valid_i = v;  bus.req0_op_i = op; bus.req0_signed_i = sg;
      bus.req0_subword_i = 1'b0; bus.req0_imm_i = 5'd0;
      bus.req0_a_i = a; bus.req0_b_i = b; bus.req0_c_i = c;
    end else begin
      bus.req1_valid_i = v;  bus.req1_op_i = op; bus.req1_signed_i = sg;
      bus.req1_subword_i = 1'b0; bus.req1_imm_i = 5'd0;
      bus.req1_a_i = a; bus.req1_b_i = b; bus.req1_c_i = c;
    end
  endtask

  // Samples the handshake cycle: returns at its negedge.
  task automatic handshake(input bit exp_r0, input bit exp_r1, input string nm);
    @(negedge clk);
    check({nm, " ready0"}, 32'(bus.req0_ready_o), 32'(exp_r0));
    check({nm, " ready1"}, 32'(bus.req1_ready_o), 32'(exp_r1));
  endtask

  // Called right after a handshake negedge; returns at the first RESP negedge.
  task automatic wait_rsp(input bit exp_id, input int exp_lat, input logic [2:0] exp_op,
                          input logic [31:0] exp_a, input string nm);
    int          k;
    bit          seen;
    bit          busy_rdy;
    bit          busy_unstable;
    logic        en1;
    logic [2:0]  op1;
    logic [31:0] a1;
    logic [31:0] exp_res;
    k = 0; seen = 0; busy_rdy = 0; busy_unstable = 0;
    en1 = 1'b0; op1 = 3'd0; a1 = 32'd0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.rsp_valid_o) begin
        seen = 1;
      end else begin
        if (bus.req0_ready_o || bus.req1_ready_o) busy_rdy = 1;
        if (k == 1) begin
          en1 = bus.mult_enable_o; op1 = bus.mult_operator_o; a1 = bus.mult_op_a_o;
        end else if (!bus.mult_enable_o || bus.mult_op_a_o !== exp_a) begin
          busy_unstable = 1;
        end
      end
    end
    exp_res = exp_q.pop_front();
    check({nm, " rsp seen"},        32'(seen),          32'd1);
    check({nm, " latency"},         32'(k),             32'(exp_lat));
    check({nm, " busy enable"},     32'(en1),           32'd1);
    check({nm, " busy operator"},   32'(op1),           32'(exp_op));
    check({nm, " busy op_a"},       a1,                 exp_a);
    check({nm, " busy stable"},     32'(busy_unstable), 32'd0);
    check({nm, " ready in busy"},   32'(busy_rdy),      32'd0);
    check({nm, " rsp_id"},          32'(bus.rsp_id_o),  32'(exp_id));
    check({nm, " rsp_result"},      bus.rsp_result_o,   exp_res);
    check({nm, " enable in resp"},  32'(bus.mult_enable_o), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          sel;
    logic [2:0]  op;
    logic [1:0]  sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input string nm);
    int p0;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b1;
    drive_req(v.sel, 1'b1, v.op, v.sg, v.a, v.b, v.c);
    exp_q.push_back(v.exp_res);
    p0 = ex_pulses;
    handshake(!v.sel, v.sel, nm);
    @(posedge clk); #1;
    drive_req(v.sel, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0);
    wait_rsp(v.sel, v.exp_lat, v.op, v.a, nm);
    check({nm, " ex_ready pulses"}, 32'(ex_pulses - p0), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int  t1;
    int  t2;
    bit  ok;
    bit  seen_rsp;

    rst_n = 1'b0;
    bus.rsp_ready_i = 1'b1;
    // tie stimulus already presented while in reset
    drive_req(1'b0, 1'b1, OP_MAC32, 2'b00, 32'd3, 32'd4, 32'd5);
    drive_req(1'b1, 1'b1, OP_MAC32, 2'b00, 32'd2, 32'd2, 32'd0);

    vecs[0] = '{1'b0, OP_MAC32, 2'b00, 32'd3,        32'd4,        32'd5,   32'd17,       2};
    vecs[1] = '{1'b1, OP_MAC32, 2'b00, 32'd2,        32'd2,        32'd0,   32'd4,        2};
    vecs[2] = '{1'b0, OP_MSU32, 2'b00, 32'd5,        32'd6,        32'd100, 32'd70,       2};
    vecs[3] = '{1'b1, OP_MUL_H, 2'b11, 32'hFFFFFFFF, 32'h00000002, 32'd0,   32'hFFFFFFFF, 5};
    vecs[4] = '{1'b0, OP_MUL_H, 2'b00, 32'hFFFFFFFF, 32'h00000002, 32'd0,   32'h00000001, 5};
    vecs[5] = '{1'b1, OP_MAC32, 2'b00, 32'h00010000, 32'h00010000, 32'd7,   32'd7,        2};
    vecs[6] = '{1'b0, OP_MUL_I, 2'b00, 32'd7,        32'd9,        32'd0,   32'd63,       2};

    // reset values with both requesters valid
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("in reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready0 before first clock", 32'(bus.req0_ready_o), 32'd0);
    check("ready1 before first clock", 32'(bus.req1_ready_o), 32'd0);

    // tie round 1: requester 0 wins the first tie in both builds
    exp_q.push_back(32'd17);
    handshake(1'b1, 1'b0, "tie1");
    t1 = cyc;
    wait_rsp(1'b0, 2, OP_MAC32, 32'd3, "tie1");

    // tie round 2: both still valid
    exp_q.push_back(RR ? 32'd4 : 32'd17);
    handshake(!RR, RR, "tie2");
    t2 = cyc;
    check("tie throughput cycles", 32'(t2 - t1), 32'd3);
    @(posedge clk); #1;
    if (RR) drive_req(1'b1, 1'b0, OP_MAC32, 2'b00, 32'd0, 32'd0, 32'd0);
    else    drive_req(1'b0, 1'b0, OP_MAC32, 2'b00, 32'd0, 32'd0, 32'd0);
    wait_rsp(RR, 2, OP_MAC32, RR ? 32'd2 : 32'd3, "tie2");

    // round 3: the remaining requester alone
    exp_q.push_back(RR ? 32'd17 : 32'd4);
    handshake(RR, !RR, "tie3");
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, OP_MAC32, 2'b00, 32'd0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, OP_MAC32, 2'b00, 32'd0, 32'd0, 32'd0);
    wait_rsp(!RR, 2, OP_MAC32, RR ? 32'd3 : 32'd2, "tie3");

    // table of single-requester transactions
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // response held off for 5 cycles while requester 1 waits
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    drive_req(1'b0, 1'b1, OP_MAC32, 2'b00, 32'd10, 32'd10, 32'd1);
    exp_q.push_back(32'd101);
    handshake(1'b1, 1'b0, "hold");
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, OP_MAC32, 2'b00, 32'd0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b1, OP_MAC32, 2'b00, 32'd1, 32'd1, 32'd1);
    wait_rsp(1'b0, 2, OP_MAC32, 32'd10, "hold");
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_id_o !== 1'b0 ||
          bus.rsp_result_o !== 32'd101 || bus.req0_ready_o || bus.req1_ready_o) ok = 0;
    end
    check("hold resp stable", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    check("hold release rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
    check("hold release ready1", 32'(bus.req1_ready_o), 32'd0);
    @(posedge clk); #1;
    exp_q.push_back(32'd2);
    handshake(1'b0, 1'b1, "after hold");
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, OP_MAC32, 2'b00, 32'd0, 32'd0, 32'd0);
    wait_rsp(1'b1, 2, OP_MAC32, 32'd1, "after hold");

    // reset in the second BUSY cycle of a high multiply
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, OP_MUL_H, 2'b11, 32'hFFFFFFFF, 32'd2, 32'd0);
    handshake(1'b1, 1'b0, "abort");
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, OP_MAC32, 2'b00, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid-busy reset");
    seen_rsp = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen_rsp = 1;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.rsp_valid_o) seen_rsp = 1;
    end
    check("abort no rsp_valid", 32'(seen_rsp), 32'd0);
    check("abort state idle", 32'(dbg_state), 32'd0);
    run_vec('{1'b1, OP_MAC32, 2'b00, 32'd6, 32'd7, 32'd8, 32'd50, 2}, "post-abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
